// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling and a small
// first-word-fall-through receive FIFO on a valid/ready interface.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 10_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Oversample divider: one tick per 1/16 bit.
    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int DW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       rxs;

    // Two flops bring the asynchronous line into the clock domain; idle is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], rx};
    end

    assign rxs = sync_q[1];

    // ------------------------------------------------------------------
    // Tick divider
    // ------------------------------------------------------------------
    logic [DW-1:0] div_q;
    logic          tick;
    logic          div_clr;

    assign tick = (div_q == DW'(DIV - 1));

    // Free-running divider, re-phased on the start edge so ticks line up with bit centres.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                div_q <= '0;
        else if (div_clr || tick) div_q <= '0;
        else                      div_q <= div_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] s_q, s_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shreg_q, shreg_d;
    logic       push;
    logic       ferr_d;

    // FSM state, sample counter, bit index and assembled byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    // Next-state logic: validate start at mid-bit, sample data and stop at bit centres.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        div_clr = 1'b0;
        push    = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    s_d     = '0;
                    div_clr = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        if (rxs) begin
                            // Line went back high before mid-start: a glitch, drop it.
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            s_d     = '0;
                            bit_d   = '0;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        // LSB arrives first, so shifting in from the top leaves it at bit 0.
                        shreg_d = {rxs, shreg_q[7:1]};
                        s_d     = '0;
                        if (bit_q == 3'd7) state_d = STOP;
                        else               bit_d   = bit_q + 3'd1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        // Leave at mid-stop so a back-to-back start edge is not missed.
                        s_d     = '0;
                        state_d = IDLE;
                        if (rxs) push   = 1'b1;
                        else     ferr_d = 1'b1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // ------------------------------------------------------------------
    // Receive FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          wr_en;

    assign rx_valid = (count != '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_en    = push && (!full || pop);
    assign rx_data  = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= shreg_q;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Error pulses, registered so they line up with the FIFO update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_d;
            overrun   <= push && full && !pop;
        end
    end

endmodule
